aplic_axil_reg_bridge: RTL

- AXI4-Lite slave to reg_intf (a32/d32) master bridge.
- Sits directly upstream of the APLIC top configuration port: converts system-bus AXI-Lite accesses into single reg_intf request/response transactions and returns AXI B/R responses.
- One outstanding transaction at a time; read/write arbitration is round-robin.

---
 rtl/aplic_axil_reg_bridge.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/aplic_axil_reg_bridge.sv
// AXI4-Lite slave to reg_intf (a32/d32) master bridge, one transaction in flight.
// Optional REQ timeout with forced SLVERR under `APLIC_BRIDGE_TIMEOUT_EN.
module aplic_axil_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input  logic        i_clk,
    input  logic        ni_rst,
    input  logic [31:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [31:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [31:0] reg_intf_req_a32_d32_addr,
    output logic        reg_intf_req_a32_d32_write,
    output logic [31:0] reg_intf_req_a32_d32_wdata,
    output logic [3:0]  reg_intf_req_a32_d32_wstrb,
    output logic        reg_intf_req_a32_d32_valid,
    input  logic [31:0] reg_intf_resp_d32_rdata,
    input  logic        reg_intf_resp_d32_error,
    input  logic        reg_intf_resp_d32_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StWresp, StRresp} state_e;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_last_wr;  // 0 = last grant was READ
    logic        w_wr_pend;
    logic        w_rd_pend;
    logic        w_grant_wr;
    logic        w_grant_rd;
    logic        w_done;
    logic        w_tmo;
    logic [31:0] w_sel_addr;
`ifdef APLIC_BRIDGE_TIMEOUT_EN
    logic [15:0] r_cnt;
`endif

    assign w_wr_pend  = s_axil_awvalid & s_axil_wvalid;
    assign w_rd_pend  = s_axil_arvalid;
    assign w_sel_addr = w_grant_wr ? s_axil_awaddr : s_axil_araddr;

    always_ff @(posedge i_clk) begin
        if (!ni_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Round-robin: on contention, the side opposite the last grant wins.
                if (w_wr_pend && (!w_rd_pend || !r_last_wr)) begin
                    w_grant_wr  = 1'b1;
                    w_state_nxt = StReq;
                end else if (w_rd_pend) begin
                    w_grant_rd  = 1'b1;
                    w_state_nxt = StReq;
                end
            end
            StReq: begin
                if (reg_intf_resp_d32_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = r_write ? StWresp : StRresp;
                end
`ifdef APLIC_BRIDGE_TIMEOUT_EN
                else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = r_write ? StWresp : StRresp;
                end
`endif
            end
            StWresp: if (s_axil_bready) w_state_nxt = StIdle;
            StRresp: if (s_axil_rready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!ni_rst) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b0;
`ifdef APLIC_BRIDGE_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            if (w_grant_wr || w_grant_rd) begin
                r_addr    <= (w_sel_addr - BASE_ADDR) & ~32'h3;
                r_write   <= w_grant_wr;
                r_wdata   <= w_grant_wr ? s_axil_wdata : 32'h0;
                r_wstrb   <= w_grant_wr ? s_axil_wstrb : 4'h0;
                r_last_wr <= w_grant_wr;
            end
            if (w_done) begin
                r_err   <= reg_intf_resp_d32_error;
                r_rdata <= r_write ? 32'h0 : reg_intf_resp_d32_rdata;
            end
            if (w_tmo) begin
                r_err   <= 1'b1;
                r_rdata <= 32'h0;
            end
`ifdef APLIC_BRIDGE_TIMEOUT_EN
            if (w_grant_wr || w_grant_rd) begin
                r_cnt <= '0;
            end else if (r_state == StReq && !reg_intf_resp_d32_ready) begin
                r_cnt <= r_cnt + 16'd1;
            end
`endif
        end
    end

    // Every output is forced low while reset is asserted, even before the clock edge.
    assign s_axil_awready = ni_rst & w_grant_wr;
    assign s_axil_wready  = ni_rst & w_grant_wr;
    assign s_axil_arready = ni_rst & w_grant_rd;
    assign s_axil_bvalid  = ni_rst & (r_state == StWresp);
    assign s_axil_bresp   = (s_axil_bvalid && r_err) ? 2'b10 : 2'b00;
    assign s_axil_rvalid  = ni_rst & (r_state == StRresp);
    assign s_axil_rresp   = (s_axil_rvalid && r_err) ? 2'b10 : 2'b00;
    assign s_axil_rdata   = ni_rst ? r_rdata : 32'h0;

    assign reg_intf_req_a32_d32_valid = ni_rst & (r_state == StReq);
    assign reg_intf_req_a32_d32_addr  = ni_rst ? r_addr : 32'h0;
    assign reg_intf_req_a32_d32_write = ni_rst & r_write;
    assign reg_intf_req_a32_d32_wdata = ni_rst ? r_wdata : 32'h0;
    assign reg_intf_req_a32_d32_wstrb = ni_rst ? r_wstrb : 4'h0;

endmodule
